// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the 5-stage pipeline hazard controller.
//   - ctrl_state_e : sequencing FSM states (INIT, RUN, DRAIN, HALTED)
//   - bit positions of the instruction fields decoded in ID
//   - LAT_DEFAULT  : default issue-to-readable latency in cycles
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } ctrl_state_e;

  localparam int unsigned WMEM_BIT   = 31;
  localparam int unsigned WREG_BIT   = 30;
  localparam int unsigned R1_MSB     = 29;
  localparam int unsigned R1_LSB     = 25;
  localparam int unsigned R2_MSB     = 24;
  localparam int unsigned R2_LSB     = 20;
  localparam int unsigned WR_MSB     = 19;
  localparam int unsigned WR_LSB     = 15;
  localparam int unsigned ALUSRC_BIT = 10;
  localparam int unsigned BRANCH_BIT = 9;

  localparam int unsigned LAT_DEFAULT = 3;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register scoreboard of in-flight writes.
// Each register has a down-counter loaded with LAT when a writer issues and
// decremented every cycle until zero; a register is readable when its
// counter is zero (or one, when the register file forwards WB writes).
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset (clears all entries)
//   set_en_i            a register-writing instruction issues this cycle
//   set_addr_i          destination register of that instruction
//   rd_addr1_i/2_i      source registers being checked in ID
//   ready1_o/ready2_o   corresponding source is readable this cycle
//   busy_o              at least one entry is nonzero
module hazard_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NREG      = 32,
  parameter int unsigned AW        = 5,
  parameter int unsigned LAT       = LAT_DEFAULT,
  parameter int unsigned WB_BYPASS = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          set_en_i,
  input  logic [AW-1:0] set_addr_i,
  input  logic [AW-1:0] rd_addr1_i,
  input  logic [AW-1:0] rd_addr2_i,
  output logic          ready1_o,
  output logic          ready2_o,
  output logic          busy_o
);

  localparam int unsigned CW = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam logic [CW-1:0] LAT_V = CW'(LAT);
  localparam logic [CW-1:0] ONE_V = CW'(1);

  logic [CW-1:0] pend_q [NREG];
  logic [CW-1:0] pend_d [NREG];
  logic [CW-1:0] pend1;
  logic [CW-1:0] pend2;

  // A new issue overwrites whatever is pending for that register.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      pend_d[i] = pend_q[i];
      if (set_en_i && (32'(set_addr_i) == i)) begin
        pend_d[i] = LAT_V;
      end else if (pend_q[i] != '0) begin
        pend_d[i] = pend_q[i] - ONE_V;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        pend_q[i] <= '0;
      end
    end else begin
      pend_q <= pend_d;
    end
  end

  // Read muxes written as a compare loop so addresses beyond NREG read as idle.
  always_comb begin
    pend1  = '0;
    pend2  = '0;
    busy_o = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (32'(rd_addr1_i) == i) pend1 = pend_q[i];
      if (32'(rd_addr2_i) == i) pend2 = pend_q[i];
      if (pend_q[i] != '0) busy_o = 1'b1;
    end
  end

  // With WB forwarding, the value is usable in the cycle its write lands.
  always_comb begin
    ready1_o = (pend1 == '0) || ((WB_BYPASS != 0) && (pend1 == ONE_V));
    ready2_o = (pend2 == '0) || ((WB_BYPASS != 0) && (pend2 == ONE_V));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the IF/ID/EX/MEM/WB core.
// Stalls ID on read-after-write hazards using a per-register scoreboard,
// flushes IF/ID for taken branches resolved in ID, and sequences a
// halt/drain request.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   id_inst         instruction held in IF/ID
//   id_valid        IF/ID holds a real instruction
//   pcsrc           branch taken for id_inst
//   halt_req        level request to stop issue and drain
//   pc_we, ifid_we  PC / IF/ID may advance
//   ifid_flush      IF/ID loads a bubble at the next edge
//   idex_bubble     ID/EX loads a bubble
//   halted          pipeline drained and stopped
//   busy            scoreboard holds in-flight writes
// Optional (macro PIPE_HAZARD_PERF_CNT_EN):
//   stall_cycles    saturating count of RUN cycles stalled on a hazard
//   flush_count     saturating count of IF/ID flush cycles
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NREG      = 32,
  parameter int unsigned AW        = 5,
  parameter int unsigned LAT       = LAT_DEFAULT,
  parameter int unsigned WB_BYPASS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_inst,
  input  logic        id_valid,
  input  logic        pcsrc,
  input  logic        halt_req,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        halted,
  output logic        busy
`ifdef PIPE_HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  ctrl_state_e   state_q;
  ctrl_state_e   state_d;

  logic          wmem;
  logic          wreg;
  logic          alusrc;
  logic          branch;
  logic [AW-1:0] reg1;
  logic [AW-1:0] reg2;
  logic [AW-1:0] wreg1;
  logic          uses_r1;
  logic          uses_r2;
  logic          ready1;
  logic          ready2;
  logic          sb_busy;
  logic          raw;
  logic          issue;
  logic          hold;
  logic          unused_inst_bits;

  always_comb begin
    wmem    = id_inst[WMEM_BIT];
    wreg    = id_inst[WREG_BIT];
    alusrc  = id_inst[ALUSRC_BIT];
    branch  = id_inst[BRANCH_BIT];
    reg1    = AW'(id_inst[R1_MSB:R1_LSB]);
    reg2    = AW'(id_inst[R2_MSB:R2_LSB]);
    wreg1   = AW'(id_inst[WR_MSB:WR_LSB]);
    uses_r1 = 1'b1;
    // Branches compare both operands and stores need the data register,
    // even when the ALU takes an immediate.
    uses_r2 = ~alusrc | branch | wmem;
  end

  assign unused_inst_bits = ^{id_inst[14:11], id_inst[8:0]};

  hazard_scoreboard #(
    .NREG      (NREG),
    .AW        (AW),
    .LAT       (LAT),
    .WB_BYPASS (WB_BYPASS)
  ) u_scoreboard (
    .clk_i      (clk),
    .rst_ni     (rst),
    .set_en_i   (issue & wreg),
    .set_addr_i (wreg1),
    .rd_addr1_i (reg1),
    .rd_addr2_i (reg2),
    .ready1_o   (ready1),
    .ready2_o   (ready2),
    .busy_o     (sb_busy)
  );

  always_comb begin
    raw   = id_valid & ((uses_r1 & ~ready1) | (uses_r2 & ~ready2));
    issue = (state_q == RUN) & ~halt_req & id_valid & ~raw;
    hold  = (state_q != RUN) | halt_req | raw;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:    state_d = RUN;
      RUN:     if (halt_req) state_d = DRAIN;
      DRAIN: begin
        if (!halt_req)     state_d = RUN;
        else if (!sb_busy) state_d = HALTED;
      end
      HALTED:  if (!halt_req) state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    idex_bubble = 1'b1;
    if (!hold) begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      idex_bubble = ~id_valid;
    end
    // pcsrc only matters for a branch that actually leaves ID this cycle.
    ifid_flush = issue & branch & pcsrc;
    halted     = (state_q == HALTED);
    busy       = sb_busy;
  end

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if ((state_q == RUN) && raw && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (ifid_flush && (flush_count_q != '1)) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: u_dut uses default parameters
// (LAT=3, no WB forwarding), u_dut_b enables WB forwarding.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_a, inst_b;
  logic        valid_a, valid_b, pcsrc_a, halt_a;
  logic        zero_b = 1'b0;
  logic        pc_we_a, ifid_we_a, flush_a, bubble_a, halted_a, busy_a;
  logic        pc_we_b, ifid_we_b, flush_b, bubble_b, halted_b, busy_b;
`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_inst(inst_a), .id_valid(valid_a),
    .pcsrc(pcsrc_a), .halt_req(halt_a),
    .pc_we(pc_we_a), .ifid_we(ifid_we_a), .ifid_flush(flush_a),
    .idex_bubble(bubble_a), .halted(halted_a), .busy(busy_a)
`ifdef PIPE_HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cnt_a), .flush_count(flush_cnt_a)
`endif
  );

  pipe_hazard_ctrl #(.WB_BYPASS(1)) u_dut_b (
    .clk(clk), .rst(rst), .id_inst(inst_b), .id_valid(valid_b),
    .pcsrc(zero_b), .halt_req(zero_b),
    .pc_we(pc_we_b), .ifid_we(ifid_we_b), .ifid_flush(flush_b),
    .idex_bubble(bubble_b), .halted(halted_b), .busy(busy_b)
`ifdef PIPE_HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cnt_b), .flush_count(flush_cnt_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_a(input string tag, input logic pc, input logic ifw, input logic fl,
                       input logic bub, input logic hl, input logic bs);
    chk({tag, "/pc_we"},       32'(pc_we_a),   32'(pc));
    chk({tag, "/ifid_we"},     32'(ifid_we_a), 32'(ifw));
    chk({tag, "/ifid_flush"},  32'(flush_a),   32'(fl));
    chk({tag, "/idex_bubble"}, 32'(bubble_a),  32'(bub));
    chk({tag, "/halted"},      32'(halted_a),  32'(hl));
    chk({tag, "/busy"},        32'(busy_a),    32'(bs));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic wm, input logic wr, input logic [4:0] r1,
                                     input logic [4:0] r2, input logic [4:0] wd,
                                     input logic alu, input logic br);
    logic [31:0] v;
    v        = '0;
    v[31]    = wm;
    v[30]    = wr;
    v[29:25] = r1;
    v[24:20] = r2;
    v[19:15] = wd;
    v[10]    = alu;
    v[9]     = br;
    return v;
  endfunction

  logic [31:0] NOP;

  initial begin
    NOP     = mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    rst     = 1'b0;
    inst_a  = NOP;  valid_a = 1'b0;  pcsrc_a = 1'b0;  halt_a = 1'b0;
    inst_b  = NOP;  valid_b = 1'b0;

    // Reset and INIT -> RUN
    tick(); tick();
    exp_a("reset", 0, 0, 0, 1, 0, 0);
    rst = 1'b1; valid_a = 1'b1;
    #1 exp_a("init", 0, 0, 0, 1, 0, 0);
    tick();
    exp_a("run", 1, 1, 0, 0, 0, 0);

    // WB forwarding instance: producer r5, consumer stalls 2 cycles
    tick(); valid_a = 1'b0; valid_b = 1'b1; inst_b = mk(0, 1, 5'd0, 5'd0, 5'd5, 1, 0);
    #1 chk("byp/prod", 32'(pc_we_b), 32'd1);
    exp_a("idle", 1, 1, 0, 1, 0, 0);
    tick(); inst_b = mk(0, 0, 5'd5, 5'd0, 5'd0, 1, 0);
    #1 chk("byp/t1", 32'(pc_we_b), 32'd0);
    chk("byp/t1_bubble", 32'(bubble_b), 32'd1);
    tick(); #1 chk("byp/t2", 32'(pc_we_b), 32'd0);
    tick(); #1 chk("byp/t3_issue", 32'(pc_we_b), 32'd1);
    chk("byp/t3_bubble", 32'(bubble_b), 32'd0);

    // RAW on r5, no forwarding: stall t+1..t+3, issue t+4
    tick(); valid_b = 1'b0; valid_a = 1'b1; inst_a = mk(0, 1, 5'd0, 5'd0, 5'd5, 1, 0);
    #1 exp_a("raw/prod", 1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick(); inst_a = mk(0, 0, 5'd5, 5'd0, 5'd0, 1, 0);
      #1 exp_a("raw/stall", 0, 0, 0, 1, 0, 1);
    end
    tick(); #1 exp_a("raw/issue", 1, 1, 0, 0, 0, 0);

    // Immediate form ignores reg2; a store with the same fields does not
    tick(); inst_a = mk(0, 1, 5'd0, 5'd0, 5'd5, 1, 0);
    #1 exp_a("imm/prod", 1, 1, 0, 0, 0, 0);
    tick(); inst_a = mk(0, 0, 5'd0, 5'd5, 5'd0, 1, 0);
    #1 exp_a("imm/nostall", 1, 1, 0, 0, 0, 1);
    tick(); inst_a = mk(1, 0, 5'd0, 5'd5, 5'd0, 1, 0);
    #1 exp_a("st/stall2", 0, 0, 0, 1, 0, 1);
    tick(); #1 exp_a("st/stall1", 0, 0, 0, 1, 0, 1);
    tick(); #1 exp_a("st/issue", 1, 1, 0, 0, 0, 0);

    // Taken branch: one-cycle flush; pcsrc ignored without issue
    tick(); inst_a = mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 1); pcsrc_a = 1'b1;
    #1 exp_a("br/flush", 1, 1, 1, 0, 0, 0);
    tick(); valid_a = 1'b0;
    #1 exp_a("br/bubble", 1, 1, 0, 1, 0, 0);

    // Branch with RAW on reg2: no flush while stalled
    tick(); valid_a = 1'b1; pcsrc_a = 1'b0; inst_a = mk(0, 1, 5'd0, 5'd0, 5'd9, 1, 0);
    #1 exp_a("brraw/prod", 1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick(); inst_a = mk(0, 0, 5'd0, 5'd9, 5'd0, 1, 1); pcsrc_a = 1'b1;
      #1 exp_a("brraw/stall", 0, 0, 0, 1, 0, 1);
    end
    tick(); #1 exp_a("brraw/issue", 1, 1, 1, 0, 0, 0);
    tick(); pcsrc_a = 1'b0; inst_a = NOP;
    #1 exp_a("brraw/after", 1, 1, 0, 0, 0, 0);

    // Register 0 is tracked like any other
    tick(); inst_a = mk(0, 1, 5'd0, 5'd0, 5'd0, 1, 0);
    #1 exp_a("r0/prod", 1, 1, 0, 0, 0, 0);
    tick(); inst_a = NOP;
    #1 exp_a("r0/stall", 0, 0, 0, 1, 0, 1);
    tick(); valid_a = 1'b0;
    #1 exp_a("r0/idle", 1, 1, 0, 1, 0, 1);
    tick();
    tick(); valid_a = 1'b1;
    #1 exp_a("r0/clear", 1, 1, 0, 0, 0, 0);

    // Halt with pend[7]=2: two DRAIN cycles, then HALTED, release to RUN
    tick(); inst_a = mk(0, 1, 5'd0, 5'd0, 5'd7, 1, 0);
    #1 exp_a("halt/prod", 1, 1, 0, 0, 0, 0);
    tick(); valid_a = 1'b0;
    tick(); valid_a = 1'b1; inst_a = NOP; halt_a = 1'b1;
    #1 exp_a("halt/req", 0, 0, 0, 1, 0, 1);
    tick(); #1 exp_a("halt/drain1", 0, 0, 0, 1, 0, 1);
    tick(); #1 exp_a("halt/drain2", 0, 0, 0, 1, 0, 0);
    tick(); #1 exp_a("halt/halted", 0, 0, 0, 1, 1, 0);
    tick(); halt_a = 1'b0;
    #1 exp_a("halt/release", 0, 0, 0, 1, 1, 0);
    tick(); #1 exp_a("halt/run", 1, 1, 0, 0, 0, 0);

    // Abort mid-DRAIN
    tick(); inst_a = mk(0, 1, 5'd0, 5'd0, 5'd7, 1, 0);
    #1 exp_a("abort/prod", 1, 1, 0, 0, 0, 0);
    tick(); halt_a = 1'b1; inst_a = NOP;
    #1 exp_a("abort/req", 0, 0, 0, 1, 0, 1);
    tick(); #1 exp_a("abort/drain", 0, 0, 0, 1, 0, 1);
    tick(); halt_a = 1'b0;
    #1 exp_a("abort/drop", 0, 0, 0, 1, 0, 1);
    tick(); #1 exp_a("abort/run", 1, 1, 0, 0, 0, 0);

    // Reset during DRAIN clears the scoreboard
    tick(); inst_a = mk(0, 1, 5'd0, 5'd0, 5'd3, 1, 0);
    #1 exp_a("rstd/prod", 1, 1, 0, 0, 0, 0);
    tick(); halt_a = 1'b1; inst_a = mk(0, 0, 5'd3, 5'd0, 5'd0, 1, 0);
    #1 exp_a("rstd/req", 0, 0, 0, 1, 0, 1);
    tick(); rst = 1'b0;
    #1 exp_a("rstd/drain", 0, 0, 0, 1, 0, 1);
    tick(); rst = 1'b1; halt_a = 1'b0;
    #1 exp_a("rstd/init", 0, 0, 0, 1, 0, 0);
    tick(); #1 exp_a("rstd/nostall", 1, 1, 0, 0, 0, 0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core: IF, ID, EX, MEM, WB.
- Register operands are read in ID, and branches are resolved in ID.
- Keeps a per-register scoreboard of in-flight writes and stalls ID on read-after-write hazards. Also generates the IF/ID flush for taken branches and sequences a halt/drain request.
- Drives the PC write enable, the IF/ID write enable and flush, and the ID/EX bubble insert.

Parameters:
- NREG, 32: number of architectural registers.
- AW, 5: register address width.
- LAT, 3: cycles from issue out of ID until the written value is readable in ID.
- WB_BYPASS, 0: 1 means the register file forwards a same-cycle WB write to its read ports.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- id_inst  in  32  instruction currently held in IF/ID.
- id_valid  in  1  IF/ID holds a real instruction (0 = bubble).
- pcsrc  in  1  branch-taken flag from decode for id_inst.
- halt_req  in  1  level request to stop issue and drain.
- pc_we  out  1  PC may advance.
- ifid_we  out  1  IF/ID may load.
- ifid_flush  out  1  IF/ID loads a bubble at the next edge.
- idex_bubble  out  1  ID/EX loads a bubble instead of the ID instruction.
- halted  out  1  pipeline is drained and stopped.
- busy  out  1  at least one scoreboard entry is nonzero.

Behaviour:
- Field decode from id_inst:
  - wmem = [31], wreg = [30], reg1 = [29:25], reg2 = [24:20], wreg1 = [19:15], alusrc = [10], branch = [9].
- Source use:
  - uses_r1 = 1.
  - uses_r2 = ~alusrc | branch | wmem.
- Scoreboard:
  - pend[NREG], each a ceil(log2(LAT+1))-bit down-counter.
  - Every cycle each nonzero entry decrements by 1.
  - On issue with wreg=1, pend[wreg1] is set to LAT. The load takes priority over that entry's decrement and overwrites any pending value.
  - Register 0 is not special.
- Ready test: reg r is ready when pend[r]==0, or when WB_BYPASS=1 and pend[r]==1.
- raw = id_valid & ((uses_r1 & ~ready(reg1)) | (uses_r2 & ~ready(reg2))).
- FSM states: INIT, RUN, DRAIN, HALTED.
  - rst sampled low: state goes to INIT and every pend entry clears. This applies from any state, including DRAIN.
  - INIT goes to RUN on the first edge with rst high.
  - RUN goes to DRAIN when halt_req=1. That cycle issues nothing.
  - DRAIN goes to HALTED when busy=0 and halt_req=1.
  - DRAIN goes to RUN when halt_req=0 (abort).
  - HALTED goes to RUN when halt_req=0.
- Issue: issue = (state==RUN) & ~halt_req & id_valid & ~raw.
- Output rules (all combinational from state, scoreboard and inputs):
  - Hold condition: state!=RUN, or halt_req, or raw.
  - When the hold condition is true: pc_we=0, ifid_we=0, idex_bubble=1.
  - Otherwise: pc_we=1, ifid_we=1, idex_bubble = ~id_valid.
  - ifid_flush = issue & branch & pcsrc. This gives a one-cycle penalty.
  - pcsrc is ignored whenever issue=0 (a stalled branch is re-evaluated once its operands are ready).
  - halted = (state==HALTED).
  - busy = OR of all (pend!=0).
- Reset values (INIT state): pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=1, halted=0, busy=0.
- Stall latency, with the producer issuing at cycle t and the consumer in ID at t+1:
  - WB_BYPASS=0: stalls t+1..t+3, issues at t+4.
  - WB_BYPASS=1: stalls t+1..t+2, issues at t+3.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_CNT_EN.
- When defined, adds two ports:
  - stall_cycles  out 32: counts cycles with state==RUN & raw.
  - flush_count  out 32: counts cycles with ifid_flush=1.
- Both counters saturate at all-ones and clear on reset.
- When undefined, the ports and the logic are absent, and the behaviour is otherwise identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum (INIT, RUN, DRAIN, HALTED);
  - instruction bit-position constants (WMEM_BIT, WREG_BIT, R1_MSB/LSB, R2_MSB/LSB, WR_MSB/LSB, ALUSRC_BIT, BRANCH_BIT);
  - the default LAT.
- Sub-module hazard_scoreboard holds the pend array:
  - inputs: set_en, set_addr, two read addresses;
  - outputs: ready1, ready2, busy.

Test Plan:
- Reset: rst=0 for 2 cycles, then 1.
  - Required: INIT with pc_we=0 and idex_bubble=1; RUN on the next cycle with pc_we=1 and idex_bubble=0 (id_valid=1).
- RAW on r5, LAT=3, WB_BYPASS=0: issue a producer writing r5 at t, then a consumer with reg1=5.
  - Required: pc_we=0 and idex_bubble=1 for exactly t+1..t+3, issue at t+4.
  - With WB_BYPASS=1 the stall is 2 cycles.
- Immediate form: consumer with reg2=5, alusrc=1, branch=0, wmem=0, reg1 not pending.
  - Required: no stall.
- Branch: pcsrc=1 on an issuing branch.
  - Required: ifid_flush=1 for that single cycle.
  - If the same branch has a RAW hazard on reg2: ifid_flush=0 while stalled, then 1 on the issue cycle.
- Halt: halt_req=1 with pend[7]=2.
  - Required: DRAIN for 2 cycles, halted=1 once busy=0.
  - Drop halt_req: RUN and pc_we=1 on the following cycle.
  - Also check: dropping halt_req mid-DRAIN returns to RUN.
- Reset mid-DRAIN with pend[3]=3.
  - Required: busy=0 and INIT next cycle, and no stall against r3 afterwards.
